// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   alu_op_e    - 3-bit operation codes
//   alu_state_e - sequencer states
//   FLAG_*      - bit positions of N, Z, C, V inside the 4-bit flags word
//   pack_nzcv   - assembles a flags word from individual flag bits
package alu_pkg;

  typedef enum logic [2:0] {
    OP_XNOR = 3'd0,
    OP_XOR  = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational full-width logic/add/sub unit.
//   a, b   - operands (WIDTH bits)
//   op     - operation code, only 0..5 are meaningful; others yield 0
//   result - operation result
//   flags  - {N,Z,C,V} for the result
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned MSB = WIDTH - 1;

  alu_op_e          op_e;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;

  assign op_e = alu_op_e'(op);

  always_comb begin
    // SUB shares the adder as a + ~b + 1
    is_sub = (op_e == OP_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    res    = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op_e)
      OP_XNOR: res = ~(a ^ b);
      OP_XOR:  res = a ^ b;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_ADD: begin
        res = sum[MSB:0];
        c   = sum[WIDTH];
        v   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res = sum[MSB:0];
        c   = sum[WIDTH];
        v   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      default: res = '0;
    endcase
    result = res;
    flags  = pack_nzcv(res[MSB], (res == '0), c, v);
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered N-bit ALU with iterative one-bit-per-cycle shifts.
//   clk, reset_n         - clock, asynchronous active-low reset
//   in_valid / in_ready  - request handshake (op, a, b sampled on accept)
//   op, a, b             - operation and operands; shift amount is b[SHW-1:0]
//   out_valid / out_ready- result handshake
//   result, flags        - registered result and {N,Z,C,V}
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic             car_d;
  logic             shl_q;
  logic [SHW-1:0]   cnt_q;

  alu_op_e          op_e;
  logic [SHW-1:0]   amt;
  logic             accept;
  logic             is_shift;
  logic [WIDTH-1:0] comb_res;
  logic [3:0]       comb_flags;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (comb_res),
    .flags  (comb_flags)
  );

  assign op_e     = alu_op_e'(op);
  assign amt      = b[SHW-1:0];
  assign is_shift = (op_e == OP_SHL) || (op_e == OP_SHR);

  // Combinational from out_ready so a finished result can be drained and a
  // new request taken on the same edge.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    if (shl_q) begin
      sh_d  = {sh_q[MSB-1:0], 1'b0};
      car_d = sh_q[MSB];
    end else begin
      sh_d  = {1'b0, sh_q[MSB:1]};
      car_d = sh_q[0];
    end
  end

  // Partial shift values live only in sh_q; result_q changes on completion,
  // so an aborted shift never reaches the result port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      sh_q        <= '0;
      shl_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (accept) begin
      if (is_shift) begin
        if (amt == '0) begin
          result_q    <= a;
          flags_q     <= pack_nzcv(a[MSB], (a == '0), 1'b0, 1'b0);
          state_q     <= ST_DONE;
          out_valid_q <= 1'b1;
        end else begin
          sh_q        <= a;
          shl_q       <= (op_e == OP_SHL);
          cnt_q       <= amt;
          state_q     <= ST_SHIFT;
          out_valid_q <= 1'b0;
        end
      end else begin
        result_q    <= comb_res;
        flags_q     <= comb_flags;
        state_q     <= ST_DONE;
        out_valid_q <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q    <= sh_d;
            flags_q     <= pack_nzcv(sh_d[MSB], (sh_d == '0), car_d, 1'b0);
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;   // {N,Z,C,V}
    int         lat;  // edges from accept until out_valid is seen high
  } vec_t;

  vec_t vecs[$];

  // Issue one request from IDLE, wait for the result with a bounded loop,
  // then drain it. Latency 1 means out_valid is high right after the accept edge.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [7:0] va,
                        input logic [7:0] vb, output logic [7:0] r,
                        output logic [3:0] f, output int lat);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = o;
    a         = va;
    b         = vb;
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    a        = 8'($urandom);
    b        = 8'($urandom);
    lat      = 1;
    while (!out_valid && lat < 40) begin
      check({nm, " busy in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    f = flags;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    logic [3:0] f;
    int         lat;

    //             name          op    a      b      res    NZCV     lat
    vecs.push_back('{"add_ovf",  3'd4, 8'h7F, 8'h01, 8'h80, 4'b1001, 1});
    vecs.push_back('{"sub_zero", 3'd5, 8'h05, 8'h05, 8'h00, 4'b0110, 1});
    vecs.push_back('{"sub_brw",  3'd5, 8'h00, 8'h01, 8'hFF, 4'b1000, 1});
    vecs.push_back('{"shl3",     3'd6, 8'h81, 8'h03, 8'h08, 4'b0000, 4});
    vecs.push_back('{"shr1",     3'd7, 8'h81, 8'h01, 8'h40, 4'b0010, 2});
    vecs.push_back('{"shl0",     3'd6, 8'h81, 8'h00, 8'h81, 4'b1000, 1});
    vecs.push_back('{"xnor",     3'd0, 8'hF0, 8'hFF, 8'hF0, 4'b1000, 1});
    vecs.push_back('{"xor",      3'd1, 8'hA5, 8'h5A, 8'hFF, 4'b1000, 1});
    vecs.push_back('{"or_zero",  3'd2, 8'h00, 8'h00, 8'h00, 4'b0100, 1});
    vecs.push_back('{"and",      3'd3, 8'h0F, 8'h3C, 8'h0C, 4'b0000, 1});
    vecs.push_back('{"add_wrap", 3'd4, 8'hFF, 8'h01, 8'h00, 4'b0110, 1});
    vecs.push_back('{"add_negv", 3'd4, 8'h80, 8'h80, 8'h00, 4'b0111, 1});
    vecs.push_back('{"sub_v",    3'd5, 8'h80, 8'h01, 8'h7F, 4'b0011, 1});
    vecs.push_back('{"shr7",     3'd7, 8'h80, 8'h07, 8'h01, 4'b0000, 8});
    vecs.push_back('{"shl7",     3'd6, 8'h01, 8'h07, 8'h80, 4'b1000, 8});
    vecs.push_back('{"shl_mask", 3'd6, 8'hFF, 8'h0B, 8'hF8, 4'b1010, 4});
    vecs.push_back('{"shr_zero", 3'd7, 8'h03, 8'h02, 8'h00, 4'b0110, 3});

    // Reset state
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst flags", 32'(flags), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel in_ready", 32'(in_ready), 32'd1);

    // Table-driven single operations
    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
      check({vecs[i].name, " result"}, 32'(r), 32'(vecs[i].res));
      check({vecs[i].name, " flags"}, 32'(f), 32'(vecs[i].fl));
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure then same-cycle accept from DONE
    @(negedge clk);
    in_valid = 1'b1;
    op       = 3'd0;
    a        = 8'hF0;
    b        = 8'hFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp out_valid", 32'(out_valid), 32'd1);
    check("bp result", 32'(result), 32'hF0);
    check("bp flags", 32'(flags), 32'b1000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp hold valid", 32'(out_valid), 32'd1);
      check("bp hold result", 32'(result), 32'hF0);
      check("bp hold flags", 32'(flags), 32'b1000);
      check("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 3'd3;
    a         = 8'h0F;
    b         = 8'h3C;
    #1;
    check("b2b in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b out_valid", 32'(out_valid), 32'd1);
    check("b2b result", 32'(result), 32'h0C);
    check("b2b flags", 32'(flags), 32'b0000);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b drained", 32'(out_valid), 32'd0);

    // Leave a nonzero result/flags before the abort test
    run_op("pre_rst", 3'd5, 8'h00, 8'h01, r, f, lat);
    check("pre_rst result", 32'(r), 32'hFF);

    // Reset in the middle of SHL by 7
    @(negedge clk);
    in_valid = 1'b1;
    op       = 3'd6;
    a        = 8'h55;
    b        = 8'h07;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid shift valid", 32'(out_valid), 32'd0);
    check("mid shift result", 32'(result), 32'hFF);
    reset_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst in_ready", 32'(in_ready), 32'd1);
    check("post_rst out_valid", 32'(out_valid), 32'd0);
    run_op("post_add", 3'd4, 8'h01, 8'h01, r, f, lat);
    check("post_add result", 32'(r), 32'h02);
    check("post_add flags", 32'(f), 32'b0000);
    check("post_add latency", 32'(lat), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised N-bit ALU that generalises the 1-bit add/sub/logic slice to a full-width, registered unit.
- Adds logical shifts, performed iteratively at one bit per cycle, and an NZCV flag output.
- Input and output use valid/ready handshakes, so the unit sits between the register-read and writeback stages of the lab CPU datapath.
- Single-cycle ops complete in 1 cycle; shifts take 1 + shift-amount cycles.

Parameters:
- WIDTH, 32, operand/result width in bits, must be >= 2.
- SHW, $clog2(WIDTH), derived (localparam); width of the shift-amount field taken from b.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op request valid.
- in_ready  out  1  unit can accept a request this cycle.
- op  in  3  0 XNOR, 1 XOR, 2 OR, 3 AND, 4 ADD, 5 SUB, 6 SHL, 7 SHR (logical).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts only b[SHW-1:0] is used as the amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  registered {N,Z,C,V}.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, result=0, flags=0, out_valid=0, shift counter=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-shift aborts the operation; no partial result is ever presented.
- Handshake:
  - A request is accepted on a clock edge where in_valid && in_ready.
  - A result is consumed on a clock edge where out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready, which allows back-to-back ops.
  - While out_valid=1 and out_ready=0, result and flags are held stable.
- FSM states IDLE, SHIFT, DONE:
  - IDLE, accept, op 0-5: compute via alu_comb, register result and flags, go to DONE. out_valid=1 the cycle after acceptance.
  - IDLE, accept, op 6/7, amount k: load the a register, count=k, C=0, go to SHIFT. If k==0, go directly to DONE with result=a and C=0.
  - SHIFT: each cycle shift the register by 1 bit (SHL inserts 0 at LSB; SHR inserts 0 at MSB), C=bit shifted out, count--. When count reaches 0 after this cycle's shift, go to DONE. out_valid rises k+1 cycles after acceptance.
  - DONE, out_ready=0: hold.
  - DONE, out_ready=1, in_valid=1: accept the new request in the same cycle (treated as IDLE accept).
  - DONE, out_ready=1, in_valid=0: go to IDLE, out_valid=0.
- Arithmetic:
  - ADD: a+b. C=carry out of MSB. V=(a[MSB]==b[MSB]) && (res[MSB]!=a[MSB]).
  - SUB: a+~b+1. C=carry out (1 = no borrow). V=(a[MSB]!=b[MSB]) && (res[MSB]!=a[MSB]).
  - Logic ops: C=0, V=0.
  - Shifts: V=0; C as above.
  - All ops: N=result[MSB], Z=(result==0).
- in_valid is ignored while in_ready=0; op/a/b need not be held after acceptance.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum (8 codes above).
  - alu_state_e enum (IDLE, SHIFT, DONE).
  - Flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_comb: purely combinational, parametrised by WIDTH. Takes a, b, op (0-5) and returns result plus NZCV, replacing the per-bit slice chain. alu_seq owns the FSM, shifter and registers.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 -> result=0x80, flags N=1 Z=0 C=0 V=1, out_valid exactly 1 cycle after accept.
- WIDTH=8, SUB 0x05-0x05 -> 0x00, Z=1 C=1 V=0. Then SUB 0x00-0x01 -> 0xFF, N=1 C=0 V=0.
- WIDTH=8, SHL a=0x81 b=3 -> 0x08, C=0, out_valid 4 cycles after accept, in_ready=0 throughout. SHR a=0x81 b=1 -> 0x40, C=1. SHL b=0 -> 0x81, C=0, 1-cycle latency.
- Backpressure: XNOR 0xF0,0xFF -> 0xF0 N=1. Hold out_ready=0 for 5 cycles -> result/flags stable, in_ready=0. Then out_ready=1 with in_valid=1, AND 0x0F,0x3C -> accepted the same cycle, next result 0x0C.
- Reset: deassert reset_n 3 cycles into SHL by 7 -> out_valid=0, result=0, flags=0 immediately. After release, in_ready=1 and a following ADD 1+1 returns 0x02.
